dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// Shares the single-port DataMemory (256x32 RAM + LED/digit MMIO) between the pipeline
// MEM stage (CPU) and a DMA/loader master. CPU has default priority; DMA is served in
// idle cycles, via bounded starvation override, or in locked bursts. CPU is held with
// cpu_stall whenever it loses the port. Sits between MEM stage, DMA and DataMemory.
// PARAMETERS
// MAX_WAIT   4  cycles a pending DMA request may be refused before forced grant (1..15)
// BURST_MAX  8  max consecutive DMA beats under dma_lock while CPU is waiting (1..15)
// PORTS
// clk         in   1   system clock, all state on posedge
// reset_n     in   1   reset, asynchronous, active-low
// cpu_read    in   1   CPU MemRead this cycle
// cpu_write   in   1   CPU MemWrite this cycle
// cpu_addr    in   32  CPU byte address
// cpu_wdata   in   32  CPU write data
// cpu_rdata   out  32  read data to CPU (combinational passthrough of mem_rdata)
// cpu_stall   out  1   CPU access not performed this cycle; pipeline must hold
// dma_req     in   1   DMA access request; held with stable addr/data until dma_gnt
// dma_we      in   1   1 = write, 0 = read
// dma_lock    in   1   request that following beats keep the port (burst)
// dma_addr    in   32  DMA byte address
// dma_wdata   in   32  DMA write data
// dma_gnt     out  1   DMA access performed this cycle (combinational)
// dma_rvalid  out  1   registered: read data valid, one cycle after a granted read
// dma_rdata   out  32  registered read data
// dma_err     out  1   registered: pulse, DMA request to MMIO range rejected
// mem_addr    out  32  to DataMemory Address
// mem_wdata   out  32  to DataMemory Write_data
// mem_read    out  1   to DataMemory MemRead
// mem_write   out  1   to DataMemory MemWrite
// mem_rdata   in   32  from DataMemory Read_data (combinational, same cycle)
// BEHAVIOUR
// - cpu_req = cpu_read|cpu_write. Memory access is single-cycle; one owner per cycle.
// - dma_mmio = dma_addr[31:28]==4'h4. Such a request is never granted: dma_err=1 next
//   cycle for one cycle, then held off until dma_req drops; no memory access.
// - FSM states: ARB (reset), LOCK, YIELD.
//   ARB : grant DMA if dma_req && !dma_mmio && (!cpu_req || wait_cnt==MAX_WAIT),
//         else grant CPU if cpu_req. DMA grant with dma_lock=1 -> LOCK, beat_cnt=1.
//   LOCK: DMA has priority while dma_req && dma_lock. Each beat granted while cpu_req=1
//         increments beat_cnt; beat_cnt==BURST_MAX and cpu_req -> YIELD. dma_req=0 or
//         dma_lock=0 -> ARB (that cycle arbitrated as ARB). Beats with cpu_req=0 not counted.
//   YIELD: CPU granted (DMA refused) for exactly one cycle, then ARB; if cpu_req=0 -> ARB.
// - wait_cnt: +1 each cycle dma_req valid && !dma_gnt; cleared on dma_gnt or dma_req=0;
//   saturates at MAX_WAIT.
// - cpu_stall = cpu_req && dma_gnt. Stalled CPU drives no memory access.
// - Mux: dma_gnt -> mem_* from DMA (mem_read=!dma_we, mem_write=dma_we); else CPU
//   signals; idle -> mem_read=mem_write=0, addr/wdata = CPU values.
// - cpu_rdata = mem_rdata always. dma_rvalid/dma_rdata capture mem_rdata on granted read.
// - Reset (any time, async): state=ARB, counters 0, dma_rvalid=0, dma_rdata=0, dma_err=0;
//   combinational outputs follow with no grant in flight.
// TESTING
// - CPU-only stream, 10 reads/writes to 0x0..0x24 -> no stall, mem_* equals CPU inputs.
// - DMA write 0x100=0xDEADBEEF with cpu idle -> dma_gnt same cycle; DMA read next ->
//   dma_rvalid 1 cycle later, dma_rdata=0xDEADBEEF.
// - cpu_req constant, dma_req held, MAX_WAIT=4 -> dma_gnt on 5th cycle, cpu_stall=1 that
//   cycle only; repeats every 5 cycles.
// - dma_lock burst of 12 beats, cpu_req constant, BURST_MAX=8 -> 8 beats, 1 CPU cycle,
//   then DMA resumes via wait_cnt override.
// - DMA request to 0x4000000C -> no mem_write, dma_err single pulse, LED unchanged.
// - reset_n low mid-burst -> registered outputs 0 immediately; after release CPU
//   granted first cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port DataMemory (256x32 RAM + LED/digit MMIO) between the
// pipeline MEM stage (CPU) and a DMA/loader master. The CPU normally wins the
// port. DMA gets the port when the CPU is idle, when it has been refused
// MAX_WAIT times in a row, or while it holds a locked burst. A locked burst
// that keeps the CPU waiting for BURST_MAX beats hands the CPU one cycle.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cpu_read/cpu_write      CPU access strobes for this cycle
//   cpu_addr/cpu_wdata      CPU byte address and write data
//   cpu_rdata               read data to CPU (passthrough of mem_rdata)
//   cpu_stall               CPU lost the port this cycle, pipeline holds
//   dma_req/dma_we/dma_lock DMA request, direction, burst lock
//   dma_addr/dma_wdata      DMA byte address and write data
//   dma_gnt                 DMA access performed this cycle
//   dma_rvalid/dma_rdata    registered read return, one cycle after grant
//   dma_err                 registered pulse, DMA request to MMIO rejected
//   mem_*                   single-port DataMemory interface
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_LOCK  = 2'd1;
  localparam logic [1:0] ST_YIELD = 2'd2;

  localparam logic [3:0] LP_MAX_WAIT  = 4'(MAX_WAIT);
  localparam logic [3:0] LP_BURST_MAX = 4'(BURST_MAX);

  logic [1:0]  r_state;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  r_beat_cnt;
  logic        r_err_hold;
  logic        r_dma_rvalid;
  logic [31:0] r_dma_rdata;
  logic        r_dma_err;

  logic [1:0]  w_next_state;
  logic [3:0]  w_next_wait;
  logic [3:0]  w_next_beat;
  logic [3:0]  w_beat_inc;
  logic        w_cpu_req;
  logic        w_dma_mmio;
  logic        w_dma_valid;
  logic        w_lock_beat;
  logic        w_yield_cpu;
  logic        w_arb_dma;
  logic        w_dma_gnt;
  logic        w_err_fire;

  assign w_cpu_req   = cpu_read | cpu_write;
  assign w_dma_mmio  = (dma_addr[31:28] == 4'h4);
  // MMIO requests are never serviceable, so they do not count as pending
  assign w_dma_valid = dma_req & ~w_dma_mmio;

  // In LOCK the DMA keeps the port as long as it keeps asking with lock set;
  // any other LOCK cycle falls through to normal arbitration.
  assign w_lock_beat = (r_state == ST_LOCK) & w_dma_valid & dma_lock;
  assign w_yield_cpu = (r_state == ST_YIELD) & w_cpu_req;
  assign w_arb_dma   = w_dma_valid & (~w_cpu_req | (r_wait_cnt == LP_MAX_WAIT));
  assign w_dma_gnt   = w_lock_beat | (~w_yield_cpu & w_arb_dma);

  // Only the first cycle of an MMIO request raises the error; the request is
  // then ignored until dma_req drops.
  assign w_err_fire  = dma_req & w_dma_mmio & ~r_err_hold;
  assign w_beat_inc  = r_beat_cnt + 4'd1;

  // Next state and burst beat counter. Beats only count while the CPU is
  // actually being held off; the entry beat starts the count at one.
  always_comb begin
    w_next_state = ST_ARB;
    w_next_beat  = r_beat_cnt;
    if (w_lock_beat) begin
      w_next_state = ST_LOCK;
      if (w_cpu_req) begin
        w_next_beat = w_beat_inc;
        if (w_beat_inc == LP_BURST_MAX) begin
          w_next_state = ST_YIELD;
        end
      end
    end else if (w_yield_cpu) begin
      w_next_state = ST_ARB;
    end else if (w_dma_gnt && dma_lock) begin
      w_next_beat = 4'd1;
      if (w_cpu_req && (LP_BURST_MAX == 4'd1)) begin
        w_next_state = ST_YIELD;
      end else begin
        w_next_state = ST_LOCK;
      end
    end
  end

  // Starvation counter: counts refused cycles of a serviceable request and
  // saturates so the override stays armed until the grant happens.
  always_comb begin
    w_next_wait = r_wait_cnt;
    if (!w_dma_valid || w_dma_gnt) begin
      w_next_wait = 4'd0;
    end else if (r_wait_cnt != LP_MAX_WAIT) begin
      w_next_wait = r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_ARB;
      r_wait_cnt   <= 4'd0;
      r_beat_cnt   <= 4'd0;
      r_err_hold   <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= 32'd0;
      r_dma_err    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wait_cnt   <= w_next_wait;
      r_beat_cnt   <= w_next_beat;
      r_err_hold   <= dma_req & (r_err_hold | w_err_fire);
      r_dma_err    <= w_err_fire;
      r_dma_rvalid <= w_dma_gnt & ~dma_we;
      if (w_dma_gnt && !dma_we) begin
        r_dma_rdata <= mem_rdata;
      end
    end
  end

  assign dma_gnt    = w_dma_gnt;
  assign cpu_stall  = w_cpu_req & w_dma_gnt;
  assign cpu_rdata  = mem_rdata;
  assign dma_rvalid = r_dma_rvalid;
  assign dma_rdata  = r_dma_rdata;
  assign dma_err    = r_dma_err;

  // Memory port mux; an idle cycle still presents the CPU address/data.
  assign mem_addr   = w_dma_gnt ? dma_addr  : cpu_addr;
  assign mem_wdata  = w_dma_gnt ? dma_wdata : cpu_wdata;
  assign mem_read   = w_dma_gnt ? ~dma_we   : cpu_read;
  assign mem_write  = w_dma_gnt ? dma_we    : cpu_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic.
// A driver issues one cycle of stimulus at a time and pushes the response
// predicted by a reference model; a monitor pops and compares on negedge.
module tb_dmem_arbiter;

  localparam int MaxWait  = 4;
  localparam int BurstMax = 8;

  localparam int ModeOpen  = 0;
  localparam int ModeBurst = 1;
  localparam int ModeTurn  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MaxWait), .BURST_MAX(BurstMax)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] initWord(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0107);
  endfunction

  // Behavioural DataMemory: RAM plus one LED register at 0x4000000C.
  logic [31:0] ram [0:255];
  logic [31:0] ledReg;
  logic        memInit = 1'b0;

  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 256; i++) ram[i] <= initWord(i);
      ledReg <= 32'h0000_00A5;
    end else if (mem_write) begin
      if (mem_addr[31:28] == 4'h4) begin
        if (mem_addr[7:0] == 8'h0C) ledReg <= mem_wdata;
      end else begin
        ram[mem_addr[9:2]] <= mem_wdata;
      end
    end
  end

  assign mem_rdata = (mem_addr[31:28] == 4'h4) ? ledReg : ram[mem_addr[9:2]];

  typedef struct {
    logic        gnt, stall, rd, wr;
    logic [31:0] addr, wdata;
    logic        cpuRdChk;
    logic [31:0] cpuRdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } expT;

  expT expQ[$];
  int  total = 0;
  int  bad = 0;
  bit  monitorOn = 1'b0;

  // Reference model state, expressed in terms of the arbitration rules
  int          modeNow;
  int          refusedCycles;
  int          burstBeats;
  bit          errLatched;
  logic [31:0] shadow [0:255];
  logic        expRvalid, expErr;
  logic [31:0] expRdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    modeNow = ModeOpen;
    refusedCycles = 0;
    burstBeats = 0;
    errLatched = 1'b0;
    expRvalid = 1'b0;
    expRdata = 32'd0;
    expErr = 1'b0;
  endtask

  // Drives one cycle starting just after a posedge, predicts the response,
  // then advances the model across the next posedge.
  task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                               input logic dr, input logic dwe, input logic dl,
                               input logic [31:0] da, input logic [31:0] dwd,
                               output logic granted, output logic sawGnt,
                               output logic sawStall, output logic sawErr);
    expT  e;
    logic cpuWants, dmaEligible, burstBeat, cpuTurn, dmaWins, newErr;
    logic [31:0] readVal;
    cpu_read = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dr; dma_we = dwe; dma_lock = dl; dma_addr = da; dma_wdata = dwd;

    cpuWants    = cr | cw;
    dmaEligible = dr && (da[31:28] != 4'h4);
    burstBeat   = (modeNow == ModeBurst) && dmaEligible && dl;
    cpuTurn     = (modeNow == ModeTurn) && cpuWants;
    if (burstBeat) dmaWins = 1'b1;
    else if (cpuTurn) dmaWins = 1'b0;
    else dmaWins = dmaEligible && (!cpuWants || refusedCycles >= MaxWait);

    e.gnt      = dmaWins;
    e.stall    = cpuWants && dmaWins;
    e.rd       = dmaWins ? !dwe : cr;
    e.wr       = dmaWins ? dwe : cw;
    e.addr     = dmaWins ? da : ca;
    e.wdata    = dmaWins ? dwd : cwd;
    e.cpuRdChk = cr && !dmaWins;
    e.cpuRdata = shadow[ca[9:2]];
    e.rvalid   = expRvalid;
    e.rdata    = expRdata;
    e.err      = expErr;
    expQ.push_back(e);

    #1;
    sawGnt = dma_gnt; sawStall = cpu_stall; sawErr = dma_err;
    @(posedge clk);

    readVal = shadow[da[9:2]];
    if (dmaWins && dwe) shadow[da[9:2]] = dwd;
    else if (!dmaWins && cw) shadow[ca[9:2]] = cwd;
    expRvalid = dmaWins && !dwe;
    if (dmaWins && !dwe) expRdata = readVal;
    newErr = dr && (da[31:28] == 4'h4) && !errLatched;
    expErr = newErr;
    errLatched = dr && (errLatched || newErr);
    if (!dmaEligible || dmaWins) refusedCycles = 0;
    else if (refusedCycles < MaxWait) refusedCycles++;

    if (burstBeat) begin
      if (cpuWants) begin
        burstBeats++;
        if (burstBeats == BurstMax) modeNow = ModeTurn;
      end
    end else if (cpuTurn) begin
      modeNow = ModeOpen;
    end else if (dmaWins && dl) begin
      burstBeats = 1;
      modeNow = (cpuWants && BurstMax == 1) ? ModeTurn : ModeBurst;
    end else begin
      modeNow = ModeOpen;
    end
    #1;
    granted = dmaWins;
  endtask

  always @(negedge clk) begin
    if (monitorOn && expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      checkOutput("dma_gnt", 32'(dma_gnt), 32'(e.gnt));
      checkOutput("cpu_stall", 32'(cpu_stall), 32'(e.stall));
      checkOutput("mem_read", 32'(mem_read), 32'(e.rd));
      checkOutput("mem_write", 32'(mem_write), 32'(e.wr));
      checkOutput("mem_addr", mem_addr, e.addr);
      checkOutput("mem_wdata", mem_wdata, e.wdata);
      checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(e.rvalid));
      checkOutput("dma_rdata", dma_rdata, e.rdata);
      checkOutput("dma_err", 32'(dma_err), 32'(e.err));
      if (e.cpuRdChk) checkOutput("cpu_rdata", cpu_rdata, e.cpuRdata);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic g, sg, ss, se;
    int   gntCount, stallCount, errCount, firstAt, beatsDone, runPhase, firstRun, gap;
    bit   dPend, burstSticky;
    logic dWe, dLock, cr, cw;
    logic [31:0] dAddr, dData, ca;
    int   mmioLeft, r;

    for (int i = 0; i < 256; i++) shadow[i] = initWord(i);
    modelReset();
    reset_n = 1'b0;
    cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
    repeat (2) @(posedge clk);
    #1 memInit = 1'b1;
    #1;
    checkOutput("reset_rvalid", 32'(dma_rvalid), 32'd0);
    checkOutput("reset_rdata", dma_rdata, 32'd0);
    checkOutput("reset_err", 32'(dma_err), 32'd0);
    checkOutput("reset_gnt", 32'(dma_gnt), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    monitorOn = 1'b1;

    $display("[TB] CPU-only stream");
    for (int i = 0; i < 10; i++)
      applyStimulus(i[0] == 1'b0, i[0] == 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i),
                    0, 0, 0, 32'h0, 32'h0, g, sg, ss, se);

    $display("[TB] DMA write then read with CPU idle");
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h100, 32'hDEADBEEF, g, sg, ss, se);
    checkOutput("dma_write_gnt_same_cycle", 32'(sg), 32'd1);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h100, 32'h0, g, sg, ss, se);
    checkOutput("dma_read_rvalid", 32'(dma_rvalid), 32'd1);
    checkOutput("dma_read_data", dma_rdata, 32'hDEADBEEF);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, g, sg, ss, se);

    $display("[TB] Starvation override");
    gntCount = 0; stallCount = 0; firstAt = -1;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0, g, sg, ss, se);
      if (sg) begin
        gntCount++;
        if (firstAt < 0) firstAt = c;
      end
      if (ss) stallCount++;
    end
    checkOutput("override_first_cycle", 32'(firstAt), 32'(MaxWait));
    checkOutput("override_grants", 32'(gntCount), 32'(20 / (MaxWait + 1)));
    checkOutput("override_stalls", 32'(stallCount), 32'(20 / (MaxWait + 1)));
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, g, sg, ss, se);

    $display("[TB] Locked burst against busy CPU");
    beatsDone = 0; runPhase = 0; firstRun = 0; gap = 0;
    for (int c = 0; c < 80 && beatsDone < 12; c++) begin
      applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 1, 32'h100 + 32'(beatsDone * 4), 32'h0, g, sg, ss, se);
      if (g) beatsDone++;
      case (runPhase)
        0: if (sg) begin runPhase = 1; firstRun = 1; end
        1: if (sg) firstRun++; else begin runPhase = 2; gap = 1; end
        2: if (!sg) gap++; else runPhase = 3;
        default: ;
      endcase
    end
    checkOutput("burst_beats_done", 32'(beatsDone), 32'd12);
    checkOutput("burst_first_run", 32'(firstRun), 32'(BurstMax));
    checkOutput("burst_gap", 32'(gap), 32'(MaxWait));
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, g, sg, ss, se);

    $display("[TB] DMA to MMIO");
    errCount = 0; gntCount = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 32'h0, 32'h0, c < 3, 1, 0, 32'h4000_000C, 32'h1234_5678, g, sg, ss, se);
      if (se) errCount++;
      if (sg) gntCount++;
    end
    checkOutput("mmio_err_pulses", 32'(errCount), 32'd1);
    checkOutput("mmio_grants", 32'(gntCount), 32'd0);
    checkOutput("mmio_led_unchanged", ledReg, 32'h0000_00A5);

    $display("[TB] Reset in the middle of a burst");
    for (int c = 0; c < 4; c++)
      applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h100, 32'h0, g, sg, ss, se);
    monitorOn = 1'b0;
    cpu_read = 1'b1; cpu_addr = 32'h10;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_rvalid", 32'(dma_rvalid), 32'd0);
    checkOutput("midreset_rdata", dma_rdata, 32'd0);
    checkOutput("midreset_err", 32'(dma_err), 32'd0);
    checkOutput("midreset_gnt", 32'(dma_gnt), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    modelReset();
    monitorOn = 1'b1;
    applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 1, 32'h100, 32'h0, g, sg, ss, se);
    checkOutput("post_reset_cpu_first", 32'(sg), 32'd0);

    $display("[TB] Random traffic");
    dPend = 0; burstSticky = 0; mmioLeft = 0;
    dWe = 0; dLock = 0; dAddr = 0; dData = 0;
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 9));
      cr = (r < 4); cw = (r >= 4 && r < 7);
      ca = {22'd0, 8'($urandom), 2'b00};
      if (!dPend && $urandom_range(0, 2) != 0) begin
        dPend = 1;
        dWe = 1'($urandom);
        if ($urandom_range(0, 3) == 0) burstSticky = !burstSticky;
        dLock = burstSticky;
        if ($urandom_range(0, 19) == 0) begin
          dAddr = 32'h4000_000C;
          mmioLeft = int'($urandom_range(1, 3));
        end else begin
          dAddr = {22'd0, 8'($urandom), 2'b00};
        end
        dData = $urandom;
      end
      applyStimulus(cr, cw, ca, $urandom, dPend, dWe, dLock, dAddr, dData, g, sg, ss, se);
      if (dPend) begin
        if (g) dPend = 0;
        else if (dAddr[31:28] == 4'h4) begin
          mmioLeft--;
          if (mmioLeft == 0) dPend = 0;
        end
      end
    end

    @(negedge clk); #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
